// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: multi-entry byte buffer between uart_rx and uart_tx in the
// loopback path. Absorbs back-to-back received bytes while the transmitter is
// busy and presents the oldest byte through the uart_tx en/rdy handshake.
//
// Ports:
//   clk, rst_n    system clock (rising edge), asynchronous active-low reset
//   in_valid      single-cycle write strobe (uart_rx data_ready)
//   in_data       write data, sampled only when in_valid=1
//   flush         synchronous clear of contents (overflow/drop_count kept)
//   ovf_clr       synchronous clear of overflow and drop_count
//   out_en        a byte is available (uart_tx en)
//   out_data      head-of-queue byte (uart_tx data_in)
//   out_rdy       uart_tx rdy; pop when out_en && out_rdy
//   level         number of stored entries, 0..DEPTH
//   empty/full    level==0 / level==DEPTH
//   almost_full   level >= AFULL_LEVEL
//   overflow      sticky, set when a write was dropped
//   drop_count    saturating count of dropped writes
module uart_byte_fifo #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AFULL_LEVEL = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     flush,
  input  logic                     ovf_clr,
  output logic                     out_en,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_rdy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             push;
  logic             pop;
  logic             drop;

  // All flags derive from the registered count only, never from in_valid or
  // out_rdy, so downstream logic sees glitch-free status.
  always_comb begin
    empty       = (count == '0);
    full        = (count == LW'(DEPTH));
    almost_full = (count >= LW'(AFULL_LEVEL));
    out_en      = ~empty;
    out_data    = mem[rd_ptr];
    level       = count;
  end

  // A push into a full FIFO is still accepted when the head leaves in the
  // same cycle; only a push that finds no room is a drop.
  always_comb begin
    pop  = out_en & out_rdy;
    push = in_valid & (~full | pop);
    drop = in_valid & full & ~pop;
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // A drop coinciding with ovf_clr wins: the cleared counter restarts at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (ovf_clr)                drop_count <= 8'd1;
      else if (drop_count != '1)  drop_count <= drop_count + 8'd1;
    end else if (ovf_clr) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Self-checking bench for uart_byte_fifo: a queue-based model checked every
// cycle on the falling edge, plus literal expectations at key points.
module tb_uart_byte_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AFULL = 12;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             flush;
  logic             ovf_clr;
  logic             out_en;
  logic [WIDTH-1:0] out_data;
  logic             out_rdy;
  logic [4:0]       level;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic             overflow;
  logic [7:0]       drop_count;

  int passed = 0;
  int total  = 0;

  uart_byte_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .flush(flush), .ovf_clr(ovf_clr), .out_en(out_en), .out_data(out_data),
    .out_rdy(out_rdy), .level(level), .empty(empty), .full(full),
    .almost_full(almost_full), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mq[$];
  logic       m_ovf;
  int         m_dc;
  bit         m_pop;
  bit         m_drop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_dc  = 0;
    end else begin
      m_pop  = (mq.size() > 0) && out_rdy;
      m_drop = in_valid && (mq.size() == DEPTH) && !m_pop;
      if (flush) begin
        mq.delete();
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (in_valid && !m_drop) mq.push_back(in_data);
      end
      if (m_drop) begin
        m_ovf = 1'b1;
        m_dc  = ovf_clr ? 1 : ((m_dc < 255) ? m_dc + 1 : 255);
      end else if (ovf_clr) begin
        m_ovf = 1'b0;
        m_dc  = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [7:0] dut_log[$];

  always @(negedge clk) begin
    chk("level", 32'(level), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(mq.size() >= AFULL));
    chk("out_en", 32'(out_en), 32'(mq.size() != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_count", 32'(drop_count), 32'(m_dc));
    if (mq.size() != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
    if (out_en && out_rdy) dut_log.push_back(out_data);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + 8'(i);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain_n(input int n);
    out_rdy = 1'b1;
    repeat (n) step();
    out_rdy = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    flush = 1'b0; ovf_clr = 1'b0; out_rdy = 1'b0;
    repeat (2) step();
    chk("reset_out_en", 32'(out_en), 32'd0);
    rst_n = 1'b1;

    // idle after reset
    repeat (20) step();
    chk("idle_empty", 32'(empty), 32'd1);
    chk("idle_level", 32'(level), 32'd0);

    // single byte
    in_valid = 1'b1; in_data = 8'hA5; step(); in_valid = 1'b0;
    chk("single_out_en", 32'(out_en), 32'd1);
    chk("single_data", 32'(out_data), 32'hA5);
    chk("single_level", 32'(level), 32'd1);
    step();
    chk("single_hold", 32'(out_data), 32'hA5);
    drain_n(1);
    chk("single_empty", 32'(empty), 32'd1);

    // burst and fill
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(i); step();
      if (i == 10) chk("af_11", 32'(almost_full), 32'd0);
      if (i == 11) chk("af_12", 32'(almost_full), 32'd1);
    end
    in_valid = 1'b0;
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_level", 32'(level), 32'd16);
    push_n(2, 8'h10);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("drops_2", 32'(drop_count), 32'd2);
    dut_log.delete();
    drain_n(16);
    chk("drain_count", 32'(dut_log.size()), 32'd16);
    for (int i = 0; i < 16 && i < dut_log.size(); i++)
      chk("drain_order", 32'(dut_log[i]), 32'(i));
    chk("drain_empty", 32'(empty), 32'd1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    chk("drops_cleared", 32'(drop_count), 32'd0);

    // wrap-around
    push_n(10, 8'h50);
    drain_n(10);
    push_n(16, 8'hC0);
    chk("wrap_full", 32'(full), 32'd1);
    dut_log.delete();
    drain_n(16);
    chk("wrap_count", 32'(dut_log.size()), 32'd16);
    for (int i = 0; i < 16 && i < dut_log.size(); i++)
      chk("wrap_order", 32'(dut_log[i]), 32'hC0 + 32'(i));

    // simultaneous push/pop at full
    push_n(16, 8'h30);
    dut_log.delete();
    in_valid = 1'b1; in_data = 8'h77; out_rdy = 1'b1; step();
    in_valid = 1'b0; out_rdy = 1'b0;
    chk("pp_level", 32'(level), 32'd16);
    chk("pp_drops", 32'(drop_count), 32'd0);
    drain_n(16);
    chk("pp_count", 32'(dut_log.size()), 32'd17);
    if (dut_log.size() == 17) chk("pp_last", 32'(dut_log[16]), 32'h77);
    else chk("pp_last_missing", 32'(dut_log.size()), 32'd17);

    // ovf_clr coinciding with a drop
    push_n(16, 8'h00);
    push_n(3, 8'h90);
    chk("drops_3", 32'(drop_count), 32'd3);
    in_valid = 1'b1; in_data = 8'hEE; ovf_clr = 1'b1; step();
    in_valid = 1'b0; ovf_clr = 1'b0;
    chk("clr_drop_ovf", 32'(overflow), 32'd1);
    chk("clr_drop_cnt", 32'(drop_count), 32'd1);

    // flush
    flush = 1'b1; step(); flush = 1'b0;
    push_n(5, 8'h60);
    chk("pre_flush_level", 32'(level), 32'd5);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h11; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_ovf_kept", 32'(overflow), 32'd1);
    chk("flush_cnt_kept", 32'(drop_count), 32'd1);

    // asynchronous reset mid-drain
    push_n(4, 8'hB0);
    out_rdy = 1'b1;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_en", 32'(out_en), 32'd0);
    chk("async_level", 32'(level), 32'd0);
    chk("async_ovf", 32'(overflow), 32'd0);
    out_rdy = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("post_reset_empty", 32'(empty), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_byte_fifo.md
Name: uart_byte_fifo

Overview:
- Multi-entry byte buffer placed between the UART receiver (`uart_rx`) and transmitter (`uart_tx`) in the loopback path. It replaces the single-register holding stage.
- Absorbs back-to-back received bytes while the transmitter is busy.
- Presents the oldest byte to `uart_tx` using its `en`/`rdy` handshake.
- Reports fill level and overflow status for LEDs and debug.

Parameters:
- WIDTH, 8: data width in bits.
- DEPTH, 16: number of entries; must be a power of two, ≥2.
- AFULL_LEVEL, 12: `almost_full` asserts when level ≥ this value; range 1..DEPTH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  single-cycle write strobe; connects to `uart_rx` `data_ready`.
- in_data  in  WIDTH  write data; sampled only when `in_valid`=1.
- flush  in  1  synchronous clear of contents.
- ovf_clr  in  1  synchronous clear of `overflow` and `drop_count`.
- out_en  out  1  a byte is available; drives `uart_tx` `en`.
- out_data  out  WIDTH  head-of-queue byte; drives `uart_tx` `data_in`.
- out_rdy  in  1  `uart_tx` `rdy`; a byte is consumed in any cycle where `out_en`=1 and `out_rdy`=1.
- level  out  $clog2(DEPTH)+1  current number of stored entries, 0..DEPTH.
- empty  out  1  level==0.
- full  out  1  level==DEPTH.
- almost_full  out  1  level ≥ AFULL_LEVEL.
- overflow  out  1  sticky: set when a write was dropped.
- drop_count  out  8  saturating count of dropped writes.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pointers=0, level=0, empty=1, full=0, almost_full=0, out_en=0, overflow=0, drop_count=0.
  - out_data is don't-care while empty.
  - Storage array is not reset.
  - Reset mid-operation discards all stored bytes immediately.
- Storage:
  - DEPTH×WIDTH register array.
  - Write and read pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - level is tracked as a separate counter; full and empty are not derived from pointer equality.
- Push: accepted when in_valid=1 and (full=0 or pop occurs in the same cycle).
  - in_data is written at wr_ptr, and wr_ptr increments.
- Pop: occurs when out_en=1 and out_rdy=1; rd_ptr increments.
- Read path:
  - out_data = mem[rd_ptr], combinational from registered state.
  - out_en = ~empty, registered-equivalent.
- Latency: a byte pushed in cycle N is visible with out_en=1 in cycle N+1 when the FIFO was empty.
- Ordering: strict FIFO; no byte is duplicated or reordered.
- Level update:
  - push only: +1
  - pop only: −1
  - push and pop: unchanged
  - neither: unchanged
- Full with push and pop in the same cycle: both occur, level stays DEPTH, no drop.
- Empty with in_valid=1: out_en=0 in that cycle, so no pop is possible; level becomes 1.
- Drop: in_valid=1 and full=1 with no simultaneous pop.
  - Data is discarded and storage is unchanged.
  - overflow←1; drop_count increments, saturating at 255.
- ovf_clr:
  - overflow←0, drop_count←0.
  - If a drop occurs in the same cycle, the drop wins: overflow=1, drop_count=1.
- flush:
  - Pointers←0, level←0 on the next edge.
  - A push or pop in the same cycle is ignored.
  - overflow and drop_count are unaffected.
- Handshake rule: while out_en=1 and out_rdy=0, out_data holds stable, including across concurrent pushes.
- Flag timing: all status flags are functions of registered state; none depend combinationally on in_valid or out_rdy.

Test Plan:
- Reset then idle: release rst_n, hold in_valid=0 → empty=1, out_en=0, level=0, overflow=0, drop_count=0 for 20 cycles.
- Single byte:
  - Pulse in_valid with 0xA5 at cycle N, out_rdy=0 → out_en=1 and out_data=0xA5 from N+1; level=1.
  - Raise out_rdy for one cycle → empty=1 next cycle.
- Burst and fill (DEPTH=16), out_rdy=0:
  - Push 0x00..0x0F → almost_full rises after the 12th push; full=1, level=16.
  - Push 0x10, 0x11 → overflow=1, drop_count=2.
  - Drain with out_rdy=1 → reads 0x00..0x0F in order; 0x10 and 0x11 never appear.
- Wrap-around:
  - Push 10, pop 10, then push 0xC0..0xCF (pointers wrap) → all 16 are read back in order; full=1 before draining.
- Simultaneous push/pop at full: with level=16, out_rdy=1, in_valid=1 with 0x77 → level stays 16, drop_count unchanged, 0x77 is read last.
- Control edge cases:
  - flush with level=5 → empty=1 next cycle; overflow is retained.
  - ovf_clr in the same cycle as a drop → overflow=1, drop_count=1.
  - Assert rst_n=0 asynchronously mid-drain → out_en=0 without waiting for a clock edge.
